// File: rtl/sample_axi_writer_pkg.sv
// rtl/sample_axi_writer_pkg.sv - AXI constants, FSM states and packing helper for sample_axi_writer
package sample_axi_writer_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wr_state_e;

    // Older sample in the low half, newer sample in the high half, each zero-extended.
    function automatic logic [31:0] pack_word(input logic [13:0] lo, input logic [13:0] hi);
        return {2'b00, hi, 2'b00, lo};
    endfunction

endpackage

// File: rtl/sample_axi_writer_fifo.sv
// rtl/sample_axi_writer_fifo.sv - first-word-fall-through word FIFO with occupancy count
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sample_axi_writer.sv
// rtl/sample_axi_writer.sv - packs sample pairs into words and writes them to a circular buffer via AXI4 bursts
module sample_axi_writer
    import sample_axi_writer_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                BUF_BYTES  = 4096,
    parameter int                BURST_LEN  = 8,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              enable,
    input  logic [13:0]       sample_in,
    input  logic              sample_valid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic              overflow,
    output logic              resp_error,
    output logic [15:0]       words_written
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);
    localparam logic [ADDR_W-1:0] BUF_END     = BASE_ADDR + ADDR_W'(BUF_BYTES);

    logic              half_q;
    logic [13:0]       low_q;
    logic              pack_push;
    logic [31:0]       pack_data;

    logic [31:0]       fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    wr_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] ptr_adv;
    logic [15:0]       words_q, words_d;
    logic              resp_err_q, resp_err_d;
    logic              overflow_q;
    logic              last_beat;

    assign pack_push = enable && sample_valid && half_q;
    assign pack_data = pack_word(low_q, sample_in);

    // Dropping enable throws away a half-filled word so pairs never straddle a gap.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            half_q <= 1'b0;
            low_q  <= '0;
        end else if (!enable) begin
            half_q <= 1'b0;
        end else if (sample_valid) begin
            if (!half_q) begin
                low_q <= sample_in;
            end
            half_q <= !half_q;
        end
    end

    sample_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock_50),
        .rst     (reset),
        .push_i  (pack_push),
        .wdata_i (pack_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (pack_push && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign ptr_adv   = ptr_q + BURST_BYTES;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        ptr_d         = ptr_q;
        words_d       = words_q;
        resp_err_d    = resp_err_q;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (!fifo_empty && (fifo_count >= CNT_W'(BURST_LEN))) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready) begin
                    fifo_pop = 1'b1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_d = IDLE;
                    // An errored burst still consumes its slot in the circular buffer.
                    ptr_d   = (ptr_adv == BUF_END) ? BASE_ADDR : ptr_adv;
                    if (m_axi_bresp == RESP_OKAY) begin
                        words_d = words_q + 16'(BURST_LEN);
                    end else begin
                        resp_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            ptr_q      <= BASE_ADDR;
            words_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            ptr_q      <= ptr_d;
            words_q    <= words_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign m_axi_awaddr  = ptr_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wdata   = fifo_head;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = (state_q == DATA) && last_beat;
    assign overflow      = overflow_q;
    assign resp_error    = resp_err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_sample_axi_writer.sv
// tb/tb_sample_axi_writer.sv - scoreboard bench for sample_axi_writer
module tb_sample_axi_writer;

    localparam int BURST_LEN = 8;

    logic        clock_50 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [13:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        overflow;
    logic        resp_error;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data[$];
    logic [31:0] exp_addr[$];

    bit          aw_on = 1'b1;
    bit          w_on = 1'b1;
    bit          w_toggle = 1'b0;
    int          err_idx = -1;
    int          b_count = 0;
    int          beat = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic [31:0] first_word;
    logic [31:0] last_word;

    sample_axi_writer #(
        .ADDR_W     (32),
        .BASE_ADDR  (32'h0000_0000),
        .BUF_BYTES  (64),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (16)
    ) dut (
        .clock_50      (clock_50),
        .reset         (reset),
        .enable        (enable),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .overflow      (overflow),
        .resp_error    (resp_error),
        .words_written (words_written)
    );

    always #5 clock_50 = ~clock_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave model: ready/response inputs change just after each rising edge.
    initial begin
        forever begin
            @(posedge clock_50);
            #1;
            m_axi_awready = aw_on;
            m_axi_wready  = w_toggle ? ~m_axi_wready : w_on;
            m_axi_bvalid  = 1'b1;
            m_axi_bresp   = (b_count == err_idx) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clock_50) begin
        if (reset) begin
            hold_pend = 1'b0;
            beat = 0;
        end else begin
            if (hold_pend) begin
                chk("w_hold_valid", m_axi_wvalid, 1);
                chk("w_hold_data", m_axi_wdata, held_data);
                chk("w_hold_last", m_axi_wlast, held_last);
                hold_pend = 1'b0;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_addr.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("awaddr", m_axi_awaddr, exp_addr.pop_front());
                chk("awlen", m_axi_awlen, BURST_LEN - 1);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_data.size() == 0) chk("w_unexpected", 1, 0);
                else chk("wdata", m_axi_wdata, exp_data.pop_front());
                chk("wlast", m_axi_wlast, beat == BURST_LEN - 1);
                if (beat == 0) first_word = m_axi_wdata;
                if (m_axi_wlast) last_word = m_axi_wdata;
                beat = (beat == BURST_LEN - 1) ? 0 : beat + 1;
            end else if (m_axi_wvalid) begin
                held_data = m_axi_wdata;
                held_last = m_axi_wlast;
                hold_pend = 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) b_count++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        repeat (3) @(posedge clock_50);
        #1;
        reset = 1'b0;
        enable = 1'b1;
    endtask

    task automatic send_word(input logic [13:0] lo, input logic [13:0] hi, input bit keep);
        @(posedge clock_50);
        #1;
        sample_in = lo;
        sample_valid = 1'b1;
        @(posedge clock_50);
        #1;
        sample_in = hi;
        if (keep) exp_data.push_back({2'b00, hi, 2'b00, lo});
    endtask

    task automatic end_samples();
        @(posedge clock_50);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_data.size() != 0 || exp_addr.size() != 0) && n < 2000) begin
            @(posedge clock_50);
            n++;
        end
        chk("drain_in_time", n < 2000, 1);
        repeat (6) @(posedge clock_50);
        #1;
    endtask

    initial begin
        int n;
        int base;
        bit seen_aw;

        // Reset with every input active
        enable = 1'b1;
        sample_valid = 1'b1;
        sample_in = 14'h3FFF;
        repeat (3) @(posedge clock_50);
        #1;
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_wlast", m_axi_wlast, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_words", words_written, 0);

        // Reset asserted while a burst sits in DATA
        do_reset();
        w_on = 1'b0;
        exp_addr.push_back(32'h0);
        for (int i = 0; i < 8; i++) send_word(14'(2 * i + 1), 14'(2 * i + 2), 1'b1);
        end_samples();
        n = 0;
        while (!m_axi_wvalid && n < 100) begin
            @(posedge clock_50);
            #1;
            n++;
        end
        chk("reach_data", m_axi_wvalid, 1);
        @(posedge clock_50);
        #2;
        reset = 1'b1;
        #1;
        chk("async_awvalid", m_axi_awvalid, 0);
        chk("async_wvalid", m_axi_wvalid, 0);
        exp_data.delete();
        exp_addr.delete();
        @(posedge clock_50);
        #1;
        reset = 1'b0;
        w_on = 1'b1;
        seen_aw = 1'b0;
        repeat (20) begin
            @(posedge clock_50);
            #1;
            if (m_axi_awvalid) seen_aw = 1'b1;
        end
        chk("fifo_flushed", seen_aw, 0);

        // Basic burst, with a partial word discarded by enable
        do_reset();
        @(posedge clock_50);
        #1;
        sample_in = 14'h3ABC;
        sample_valid = 1'b1;
        @(posedge clock_50);
        #1;
        sample_valid = 1'b0;
        enable = 1'b0;
        @(posedge clock_50);
        #1;
        enable = 1'b1;
        exp_addr.push_back(32'h0);
        for (int i = 0; i < 8; i++) send_word(14'(2 * i + 1), 14'(2 * i + 2), 1'b1);
        end_samples();
        drain();
        chk("s2_first_beat", first_word, 32'h0002_0001);
        chk("s2_last_beat", last_word, 32'h0010_000F);
        chk("s2_words", words_written, 8);
        chk("s2_overflow", overflow, 0);
        chk("s2_wstrb", m_axi_wstrb, 4'hF);
        chk("s2_awsize", m_axi_awsize, 3'b010);
        chk("s2_awburst", m_axi_awburst, 2'b01);

        // Stalling wready
        do_reset();
        w_toggle = 1'b1;
        exp_addr.push_back(32'h0);
        for (int i = 0; i < 8; i++) send_word(14'(2 * i + 1), 14'(2 * i + 2), 1'b1);
        end_samples();
        drain();
        w_toggle = 1'b0;
        chk("s3_words", words_written, 8);

        // Three bursts wrap the 64-byte buffer
        do_reset();
        exp_addr.push_back(32'h00);
        exp_addr.push_back(32'h20);
        exp_addr.push_back(32'h00);
        for (int i = 0; i < 24; i++) send_word(14'(16'h100 + 2 * i), 14'(16'h101 + 2 * i), 1'b1);
        end_samples();
        drain();
        chk("s4_words", words_written, 24);

        // Overflow while awready is held low
        do_reset();
        aw_on = 1'b0;
        for (int i = 0; i < 16; i++) send_word(14'(16'h200 + 2 * i), 14'(16'h201 + 2 * i), 1'b1);
        end_samples();
        chk("s5_no_overflow_at_16", overflow, 0);
        send_word(14'h3AAA, 14'h3BBB, 1'b0);
        end_samples();
        chk("s5_overflow", overflow, 1);
        exp_addr.push_back(32'h00);
        exp_addr.push_back(32'h20);
        aw_on = 1'b1;
        drain();
        chk("s5_words", words_written, 16);
        chk("s5_overflow_sticky", overflow, 1);

        // Slave error on the first burst
        do_reset();
        base = b_count;
        err_idx = b_count;
        exp_addr.push_back(32'h00);
        exp_addr.push_back(32'h20);
        for (int i = 0; i < 16; i++) send_word(14'(16'h300 + 2 * i), 14'(16'h301 + 2 * i), 1'b1);
        end_samples();
        n = 0;
        while (b_count == base && n < 500) begin
            @(posedge clock_50);
            n++;
        end
        #1;
        chk("s6_first_resp_seen", b_count != base, 1);
        chk("s6_resp_error", resp_error, 1);
        chk("s6_words_after_err", words_written, 0);
        drain();
        err_idx = -1;
        chk("s6_words_final", words_written, 8);
        chk("s6_resp_error_sticky", resp_error, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_axi_writer.md
Name: sample_axi_writer

Overview:
Downstream stage of the recovered-sample register. It consumes the 14-bit standardised sample stream, qualified by the recovery strobe, and packs two samples per 32-bit word. Packed words are buffered in a small FIFO and written to a circular memory buffer through AXI4 INCR write bursts. It flags FIFO overflow and slave error responses.

Parameters:
ADDR_W, 32, AXI address width
BASE_ADDR, 32'h0000_0000, byte address where the circular buffer starts
BUF_BYTES, 4096, circular buffer size in bytes; must be a multiple of BURST_LEN*4
BURST_LEN, 8, beats per burst (1..16)
FIFO_DEPTH, 16, word FIFO depth; power of 2, >= BURST_LEN

Ports:
clock_50  in  1  sole clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  capture enable
sample_in  in  14  standardised sample from the upstream register
sample_valid  in  1  one-cycle strobe; sample_in is valid in that cycle
m_axi_awaddr  out  ADDR_W  burst start address
m_axi_awlen  out  8  constant BURST_LEN-1
m_axi_awsize  out  3  constant 3'b010
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  constant 4'hF
m_axi_wlast  out  1  final beat of the burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready
overflow  out  1  sticky; a packed word was dropped
resp_error  out  1  sticky; a non-OKAY bresp was received
words_written  out  16  count of words acknowledged OKAY; wraps modulo 2^16

Behaviour:
- Reset (asynchronous, active-high): awvalid, wvalid, wlast, bready, overflow, resp_error and words_written go to 0. The pack half-flag clears, the FIFO empties, the address pointer loads BASE_ADDR, and the FSM enters IDLE. Reset asserted mid-burst aborts the burst immediately. There is no AXI recovery.
- Packing: samples are taken only when sample_valid=1 and enable=1.
  - The first sample goes to bits [15:0] as {2'b00, sample}.
  - The second sample goes to bits [31:16] as {2'b00, sample}.
  - The completed word is pushed into the FIFO on the clock edge that captures the second sample.
- When enable=0, the half-flag clears and any partial word is discarded. A burst already in flight still completes.
- FIFO push rules:
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A push while full with no pop is dropped and sets overflow. overflow clears only on reset.
- FSM states:
  - IDLE: when FIFO count >= BURST_LEN, go to ADDR with awvalid=1 and awaddr = pointer.
  - ADDR: hold awvalid and awaddr stable until awready=1, then go to DATA.
  - DATA: wvalid=1 and wdata = FIFO head. Each wvalid&wready pops one word.
    - wlast=1 on beat BURST_LEN-1.
    - After the last beat is accepted, go to RESP.
    - wvalid never drops while its beat is pending.
  - RESP: bready=1. When bvalid=1, return to IDLE.
    - bresp=2'b00: words_written increases by BURST_LEN.
    - Otherwise: set resp_error.
    - In both cases the pointer advances by BURST_LEN*4.
    - When the advanced pointer equals BASE_ADDR+BUF_BYTES, it wraps to BASE_ADDR.
- Bursts never cross the buffer end, since BUF_BYTES is a multiple of the burst size.
- Only one burst is outstanding at a time. W is issued only after the AW handshake.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - FSM state enum {IDLE, ADDR, DATA, RESP}.
- One sub-module, sample_fifo: a synchronous FIFO with width 32, depth FIFO_DEPTH, and outputs count, full, empty, push, pop, plus a first-word-fall-through head.
- Packer, FSM and address pointer live in the top level.

Test Plan:
1. Reset with all inputs active -> all outputs 0, awaddr=BASE_ADDR after first burst request. Assert reset during DATA -> awvalid/wvalid drop asynchronously and the FIFO empties.
2. Send 16 samples 0x0001..0x0010 with awready=wready=bvalid=1 and bresp=0, defaults -> one burst at awaddr=0x0. Beat0 wdata=0x00020001, beat7 wdata=0x00100000F with wlast=1 only on beat7; words_written=8.
3. Same stimulus with wready toggling 1/0 each cycle -> wdata/wvalid stay stable while wready=0, exactly 8 beats, wlast only on the 8th accepted beat.
4. BUF_BYTES=64, 24 words streamed -> bursts at 0x00, 0x20, then wrap to 0x00; words_written=24.
5. Hold awready=0 and push 17 packed words (34 samples) -> FIFO holds 16, overflow=1, the 17th word is absent from the data later released.
6. bresp=2'b10 on the first burst -> resp_error=1, words_written stays 0, the next burst address is 0x20.

Note on scenario 2: the intended beat7 value is 0x0010000F (sample 0x10 in [31:16], sample 0x0F in [15:0]); the "0x00100000F" text above is a typo for that value.
